// File: rtl/rotary_value_tracker_if.sv
// rtl/rotary_value_tracker_if.sv - detent, load and change-event signals of the rotary value tracker
interface rotary_value_tracker_if #(
    parameter int WIDTH = 8
);
    logic             i_cnt;
    logic             i_cnt_cw;
    logic             i_load;
    logic [WIDTH-1:0] i_load_val;
    logic [WIDTH-1:0] o_value;
    logic             o_evt_valid;
    logic             i_evt_ready;
    logic             o_evt_dir;
    logic             o_clamped;

    modport master (
        output i_cnt, i_cnt_cw, i_load, i_load_val, i_evt_ready,
        input  o_value, o_evt_valid, o_evt_dir, o_clamped
    );

    modport slave (
        input  i_cnt, i_cnt_cw, i_load, i_load_val, i_evt_ready,
        output o_value, o_evt_valid, o_evt_dir, o_clamped
    );
endinterface

// File: rtl/rotary_value_tracker.sv
// rtl/rotary_value_tracker.sv - bounded value register driven by encoder detents with velocity acceleration
module rotary_value_tracker #(
    parameter int WIDTH       = 8,
    parameter int MIN_VAL     = 0,
    parameter int MAX_VAL     = 99,
    parameter int INIT_VAL    = 0,
    parameter int WRAP        = 0,
    parameter int FAST_WINDOW = 50000,
    parameter int FAST_STEP   = 4
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    rotary_value_tracker_if.slave bus
);
    localparam int VW = WIDTH + 2;
    localparam int IW = $clog2(FAST_WINDOW + 1);

    typedef logic signed [VW-1:0] ext_t;

    localparam ext_t           MIN_X  = ext_t'(MIN_VAL);
    localparam ext_t           MAX_X  = ext_t'(MAX_VAL);
    localparam ext_t           ONE_X  = ext_t'(1);
    localparam ext_t           STEP_X = ext_t'(FAST_STEP);
    localparam logic [IW-1:0]  WIN    = IW'(FAST_WINDOW);
    localparam logic [WIDTH-1:0] INIT = WIDTH'(INIT_VAL);

    logic [WIDTH-1:0] value;
    logic             evt_valid;
    logic             evt_dir;
    logic             clamped;
    logic [IW-1:0]    interval;
    logic             last_dir;

    logic accept;
    ext_t cur_x;
    ext_t step_x;
    ext_t raw_x;
    ext_t next_x;
    ext_t load_x;
    ext_t lv_x;
    logic bound_hit;

    assign accept = bus.i_cnt & ~bus.i_load;

    // All arithmetic is done two bits wider so v+step and v-step never overflow.
    always_comb begin
        cur_x     = ext_t'({2'b00, value});
        step_x    = ONE_X;
        raw_x     = cur_x;
        next_x    = cur_x;
        bound_hit = 1'b0;
        if (interval < WIN && bus.i_cnt_cw == last_dir) begin
            step_x = STEP_X;
        end
        if (bus.i_cnt_cw) begin
            raw_x = cur_x + step_x;
            if (raw_x > MAX_X) begin
                bound_hit = 1'b1;
                next_x    = (WRAP != 0) ? MIN_X + (raw_x - MAX_X - ONE_X) : MAX_X;
            end else begin
                next_x = raw_x;
            end
        end else begin
            raw_x = cur_x - step_x;
            if (raw_x < MIN_X) begin
                bound_hit = 1'b1;
                next_x    = (WRAP != 0) ? MAX_X - (MIN_X - raw_x - ONE_X) : MIN_X;
            end else begin
                next_x = raw_x;
            end
        end
    end

    // Loaded values are forced into range regardless of wrap mode.
    always_comb begin
        lv_x   = ext_t'({2'b00, bus.i_load_val});
        load_x = lv_x;
        if (lv_x < MIN_X) begin
            load_x = MIN_X;
        end else if (lv_x > MAX_X) begin
            load_x = MAX_X;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            value     <= INIT;
            evt_valid <= 1'b0;
            evt_dir   <= 1'b0;
            clamped   <= 1'b0;
            interval  <= WIN;
            last_dir  <= 1'b0;
        end else begin
            clamped <= 1'b0;
            if (bus.i_load) begin
                value    <= load_x[WIDTH-1:0];
                interval <= WIN;
            end else if (accept) begin
                value    <= next_x[WIDTH-1:0];
                interval <= '0;
                last_dir <= bus.i_cnt_cw;
                evt_dir  <= bus.i_cnt_cw;
                clamped  <= bound_hit && (WRAP == 0);
            end else if (interval < WIN) begin
                interval <= interval + 1'b1;
            end

            if (accept) begin
                evt_valid <= 1'b1;
            end else if (evt_valid && bus.i_evt_ready) begin
                evt_valid <= 1'b0;
            end
        end
    end

    assign bus.o_value     = value;
    assign bus.o_evt_valid = evt_valid;
    assign bus.o_evt_dir   = evt_dir;
    assign bus.o_clamped   = clamped;
endmodule

// File: tb/tb_rotary_value_tracker.sv
// tb/tb_rotary_value_tracker.sv - saturating and wrapping trackers checked against a behavioural model
module tb_rotary_value_tracker;
    localparam int WIN  = 100;
    localparam int STEP = 4;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    rotary_value_tracker_if #(.WIDTH(8)) bus_s ();
    rotary_value_tracker_if #(.WIDTH(8)) bus_w ();

    rotary_value_tracker #(
        .WIDTH(8), .MIN_VAL(0), .MAX_VAL(99), .INIT_VAL(0), .WRAP(0),
        .FAST_WINDOW(WIN), .FAST_STEP(STEP)
    ) dut_s (.i_clk(clk), .i_rst(rst), .bus(bus_s.slave));

    rotary_value_tracker #(
        .WIDTH(8), .MIN_VAL(10), .MAX_VAL(19), .INIT_VAL(10), .WRAP(1),
        .FAST_WINDOW(WIN), .FAST_STEP(STEP)
    ) dut_w (.i_clk(clk), .i_rst(rst), .bus(bus_w.slave));

    int m_min [2] = '{0, 10};
    int m_max [2] = '{99, 19};
    int m_init[2] = '{0, 10};
    bit m_wrap[2] = '{1'b0, 1'b1};

    int m_val [2];
    bit m_valid[2];
    bit m_dir [2];
    bit m_clamp[2];
    int m_last[2];
    bit m_ldir[2];

    int edge_no = 0;
    int checks  = 0;
    int passed  = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks = checks + 1;
        assert (obs === exp) passed = passed + 1;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    endtask

    function automatic int clampv(input int v, input int lo, input int hi);
        if (v < lo) return lo;
        if (v > hi) return hi;
        return v;
    endfunction

    task automatic model_edge(input int d, input bit cnt, input bit cw, input bit ld,
                              input int lv, input bit rdy, input bit r);
        bit xfer;
        bit fast;
        int nv;
        if (r) begin
            m_val[d] = m_init[d]; m_valid[d] = 0; m_dir[d] = 0;
            m_clamp[d] = 0; m_last[d] = -1; m_ldir[d] = 0;
            return;
        end
        xfer = m_valid[d] && rdy;
        m_clamp[d] = 0;
        if (ld) begin
            m_val[d]  = clampv(lv, m_min[d], m_max[d]);
            m_last[d] = -1;
            if (xfer) m_valid[d] = 0;
        end else if (cnt) begin
            fast = (m_last[d] >= 0) && (edge_no - m_last[d] - 1 < WIN) && (cw == m_ldir[d]);
            nv = cw ? m_val[d] + (fast ? STEP : 1) : m_val[d] - (fast ? STEP : 1);
            if (nv > m_max[d]) begin
                nv = m_wrap[d] ? m_min[d] + (nv - m_max[d] - 1) : m_max[d];
                m_clamp[d] = !m_wrap[d];
            end else if (nv < m_min[d]) begin
                nv = m_wrap[d] ? m_max[d] - (m_min[d] - nv - 1) : m_min[d];
                m_clamp[d] = !m_wrap[d];
            end
            m_val[d] = nv; m_valid[d] = 1; m_dir[d] = cw;
            m_ldir[d] = cw; m_last[d] = edge_no;
        end else if (xfer) begin
            m_valid[d] = 0;
        end
    endtask

    task automatic tick(input bit cnt, input bit cw, input bit ld, input int lv,
                        input bit rdy, input bit r);
        bus_s.i_cnt = cnt; bus_s.i_cnt_cw = cw; bus_s.i_load = ld;
        bus_s.i_load_val = 8'(lv); bus_s.i_evt_ready = rdy;
        bus_w.i_cnt = cnt; bus_w.i_cnt_cw = cw; bus_w.i_load = ld;
        bus_w.i_load_val = 8'(lv); bus_w.i_evt_ready = rdy;
        rst = r;
        @(posedge clk);
        edge_no = edge_no + 1;
        model_edge(0, cnt, cw, ld, lv, rdy, r);
        model_edge(1, cnt, cw, ld, lv, rdy, r);
        #1;
        chk("sat_value", 32'(bus_s.o_value), 32'(m_val[0]));
        chk("sat_valid", 32'(bus_s.o_evt_valid), 32'(m_valid[0]));
        chk("sat_dir", 32'(bus_s.o_evt_dir), 32'(m_dir[0]));
        chk("sat_clamped", 32'(bus_s.o_clamped), 32'(m_clamp[0]));
        chk("wrap_value", 32'(bus_w.o_value), 32'(m_val[1]));
        chk("wrap_valid", 32'(bus_w.o_evt_valid), 32'(m_valid[1]));
        chk("wrap_dir", 32'(bus_w.o_evt_dir), 32'(m_dir[1]));
        chk("wrap_clamped", 32'(bus_w.o_clamped), 32'(m_clamp[1]));
    endtask

    task automatic idle(input int n, input bit rdy);
        repeat (n) tick(0, 0, 0, 0, rdy, 0);
    endtask

    initial begin
        bit c, w, l, y, r;
        tick(0, 0, 0, 0, 0, 1);
        tick(0, 0, 0, 0, 0, 1);
        chk("reset_value_sat", 32'(bus_s.o_value), 32'd0);
        chk("reset_value_wrap", 32'(bus_w.o_value), 32'd10);
        chk("reset_valid", 32'(bus_s.o_evt_valid), 32'd0);

        // Acceleration: 10-cycle CW detents from 10, then a direction change.
        tick(0, 0, 1, 10, 1, 0);
        idle(9, 1); tick(1, 1, 0, 0, 1, 0); chk("accel_11", 32'(bus_s.o_value), 32'd11);
        idle(9, 1); tick(1, 1, 0, 0, 1, 0); chk("accel_15", 32'(bus_s.o_value), 32'd15);
        idle(9, 1); tick(1, 1, 0, 0, 1, 0); chk("accel_19", 32'(bus_s.o_value), 32'd19);
        idle(9, 1); tick(1, 0, 0, 0, 1, 0); chk("dirchg_18", 32'(bus_s.o_value), 32'd18);

        // Saturation at both bounds.
        tick(0, 0, 1, 97, 1, 0);
        tick(1, 1, 0, 0, 1, 0); chk("sat_98", 32'(bus_s.o_value), 32'd98);
        idle(4, 1);
        tick(1, 1, 0, 0, 1, 0); chk("sat_99", 32'(bus_s.o_value), 32'd99);
        chk("sat_clamp_pulse", 32'(bus_s.o_clamped), 32'd1);
        idle(2, 1);
        tick(1, 1, 0, 0, 1, 0); chk("sat_hold_99", 32'(bus_s.o_value), 32'd99);
        chk("sat_hold_clamp", 32'(bus_s.o_clamped), 32'd1);
        chk("sat_hold_event", 32'(bus_s.o_evt_valid), 32'd1);
        tick(0, 0, 1, 0, 1, 0);
        idle(2, 1);
        tick(1, 0, 0, 0, 1, 0); chk("sat_min_0", 32'(bus_s.o_value), 32'd0);
        chk("sat_min_clamp", 32'(bus_s.o_clamped), 32'd1);

        // Wrap-around in both directions on the 10..19 tracker.
        tick(0, 0, 1, 17, 1, 0);
        tick(1, 1, 0, 0, 1, 0); idle(3, 1);
        tick(1, 1, 0, 0, 1, 0); chk("wrap_cw_12", 32'(bus_w.o_value), 32'd12);
        chk("wrap_no_clamp", 32'(bus_w.o_clamped), 32'd0);
        tick(0, 0, 1, 12, 1, 0);
        tick(1, 0, 0, 0, 1, 0); chk("wrap_11", 32'(bus_w.o_value), 32'd11);
        idle(3, 1);
        tick(1, 0, 0, 0, 1, 0); chk("wrap_ccw_17", 32'(bus_w.o_value), 32'd17);

        // Event coalescing and handshake.
        idle(3, 1); chk("hs_drained", 32'(bus_s.o_evt_valid), 32'd0);
        tick(1, 1, 0, 0, 0, 0); idle(2, 0);
        tick(1, 1, 0, 0, 0, 0); idle(2, 0);
        tick(1, 0, 0, 0, 0, 0);
        chk("hs_coalesce_valid", 32'(bus_s.o_evt_valid), 32'd1);
        chk("hs_coalesce_dir", 32'(bus_s.o_evt_dir), 32'd0);
        tick(1, 1, 0, 0, 1, 0);
        chk("hs_ready_with_detent", 32'(bus_s.o_evt_valid), 32'd1);
        tick(0, 0, 0, 0, 1, 0);
        chk("hs_drop", 32'(bus_s.o_evt_valid), 32'd0);

        // Load beats a simultaneous detent and disarms acceleration.
        tick(1, 0, 0, 0, 1, 0); idle(1, 1);
        tick(1, 1, 1, 200, 0, 0);
        chk("load_clamp_99", 32'(bus_s.o_value), 32'd99);
        chk("load_no_event", 32'(bus_s.o_evt_valid), 32'd0);
        idle(2, 0);
        tick(1, 0, 0, 0, 0, 0); chk("load_step1_98", 32'(bus_s.o_value), 32'd98);

        tick(0, 0, 0, 0, 0, 1);
        chk("rst_value", 32'(bus_s.o_value), 32'd0);
        chk("rst_valid", 32'(bus_s.o_evt_valid), 32'd0);
        chk("rst_dir", 32'(bus_s.o_evt_dir), 32'd0);
        chk("rst_wrap_value", 32'(bus_w.o_value), 32'd10);

        for (int i = 0; i < 2000; i++) begin
            c = ($urandom_range(0, 3) == 0);
            w = $urandom_range(0, 1) != 0;
            l = ($urandom_range(0, 31) == 0);
            y = $urandom_range(0, 1) != 0;
            r = ($urandom_range(0, 499) == 0);
            tick(c, w, l, int'($urandom_range(0, 255)), y, r);
        end

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule

// File: doc/rotary_value_tracker.md
# rotary_value_tracker

Downstream consumer of the incremental rotary encoder driver: turns its one-cycle detent pulses (count + direction) into a bounded, user-visible value register with optional velocity acceleration. Each accepted detent updates the value and raises a valid/ready change event for the UI/control logic. It sits between the encoder driver and any register-file or display consumer, all in the same clock domain.

## Interface

Parameters:
- WIDTH, 8, bit width of the value.
- MIN_VAL, 0, lower bound (unsigned, inclusive).
- MAX_VAL, 99, upper bound (unsigned, inclusive); MIN_VAL < MAX_VAL < 2^WIDTH.
- INIT_VAL, 0, value after reset; must lie in [MIN_VAL, MAX_VAL].
- WRAP, 0, 0 = saturate at bounds, 1 = wrap around.
- FAST_WINDOW, 50000, cycles; a detent arriving sooner than this after the previous one in the same direction is "fast".
- FAST_STEP, 4, step size for fast detents; 1 ≤ FAST_STEP ≤ MAX_VAL−MIN_VAL.

Ports:
- i_clk  in  1  clock.
- i_rst  in  1  synchronous reset, active-high.
- i_cnt  in  1  one-cycle detent pulse from the encoder driver.
- i_cnt_cw  in  1  detent direction, 1 = clockwise; qualified by i_cnt.
- i_load  in  1  load i_load_val into the value.
- i_load_val  in  WIDTH  value to load.
- o_value  out  WIDTH  current value.
- o_evt_valid  out  1  change event pending.
- i_evt_ready  in  1  consumer accepts event.
- o_evt_dir  out  1  direction of the most recent detent in the pending event (1 = CW).
- o_clamped  out  1  one-cycle pulse: last detent hit a bound in saturate mode.

## Operation

- Reset values: o_value = INIT_VAL, o_evt_valid = 0, o_evt_dir = 0, o_clamped = 0, interval counter = FAST_WINDOW, last direction = 0.
- Interval counter: increments every cycle, saturating at FAST_WINDOW; cleared to 0 on each accepted detent. Width = clog2(FAST_WINDOW+1).
- Detent accepted when i_cnt = 1 and i_load = 0; i_cnt_cw ignored when i_cnt = 0.
- Step: FAST_STEP if interval < FAST_WINDOW and i_cnt_cw equals last direction; else 1. Last direction updated on every accepted detent.
- Arithmetic in WIDTH+2 bits, no intermediate overflow. CW: v+step; CCW: v−step.
- Saturate (WRAP=0): result clamped to [MIN_VAL, MAX_VAL]; o_clamped pulses on a detent where clamping altered the result, including a detent at a bound that leaves the value unchanged.
- Wrap (WRAP=1): CW past MAX_VAL → MIN_VAL + (v+step−MAX_VAL−1); CCW past MIN_VAL → MAX_VAL − (MIN_VAL−(v−step)−1). o_clamped stays 0.
- Every accepted detent raises an event, even when the value is unchanged (clamped).
- Event coalescing: a detent while o_evt_valid = 1 keeps valid high and overwrites o_evt_dir; no queueing, no lost-event flag.
- Load: i_load has priority over a simultaneous i_cnt (that detent is dropped). Value = i_load_val clamped to [MIN_VAL, MAX_VAL] (clamped even when WRAP=1). Interval counter set to FAST_WINDOW. No event raised, o_clamped not pulsed, pending event untouched.

## Timing

- Detent at cycle N (i_cnt high at edge N): o_value, o_evt_dir and o_clamped updated at edge N; o_evt_valid high from cycle N+1. Latency 1 cycle.
- Load at cycle N: o_value updated at edge N.
- Handshake: transfer on a cycle with o_evt_valid & i_evt_ready; o_evt_valid drops next cycle unless an accepted detent occurs in the same cycle, in which case it stays high (new event).
- o_evt_valid is independent of i_evt_ready; it never drops without a transfer except on reset.
- i_rst mid-operation overrides detent, load and handshake in that cycle; pending event discarded.
- Back-to-back detents on consecutive cycles are each processed.

## Test plan

- Reset, defaults: 3 CW detents spaced 60000 cycles → o_value 0→1→2→3, 3 events with o_evt_dir = 1, o_clamped never high.
- FAST_WINDOW=100, FAST_STEP=4: CW detents 10 cycles apart from 10 → 11, 15, 19; then CCW after 10 cycles → 18 (direction change, step 1).
- Saturate: value 98, fast CW step 4 → 99 with o_clamped pulse; another CW → stays 99, o_clamped pulse, event still raised; CCW from MIN_VAL 0 → 0, o_clamped.
- WRAP=1, MIN 10, MAX 19: value 18, step 4 CW → 12; value 11, step 4 CCW → 17; o_clamped stays 0.
- Handshake: i_evt_ready = 0, 3 detents (CW, CW, CCW) → o_evt_valid stays high, o_evt_dir = 0; raise ready with a simultaneous detent → valid stays high; next ready with no detent → valid drops one cycle later.
- Load priority: i_load = 1, i_load_val = 200 and i_cnt = 1 same cycle → o_value = 99, no event, next detent uses step 1; i_rst asserted with pending event → all outputs at reset values the next cycle.
